// File: rtl/linear2_neuron_mac_if.sv
// Bus between the layer-2 controller/weight memory and the neuron MAC engine:
// start/activation request, weight row from memory, rd strobe, status and results.
interface linear2_neuron_mac_if #(
    parameter int DW = 10,
    parameter int N  = 10
);
    logic          start;
    logic [N*DW-1:0] x_vec;
    logic [DW-1:0] w0, w1, w2, w3, w4, w5, w6, w7, w8, w9;
    logic          mem_rd;
    logic          busy;
    logic          done;
    logic [N*DW-1:0] y_vec;

    modport master (
        output start, x_vec,
        output w0, w1, w2, w3, w4, w5, w6, w7, w8, w9,
        input  mem_rd, busy, done, y_vec
    );

    modport slave (
        input  start, x_vec,
        input  w0, w1, w2, w3, w4, w5, w6, w7, w8, w9,
        output mem_rd, busy, done, y_vec
    );
endinterface

// File: rtl/linear2_neuron_mac.sv
// Fully-connected layer-2 engine: streams 10 weight rows from memory through a
// 2-stage multiply/adder-tree pipeline, then shift, optional ReLU and saturation.
module linear2_neuron_mac #(
    parameter int DW    = 10,
    parameter int N     = 10,
    parameter int FRAC  = 4,
    parameter int ACC_W = 24,
    parameter int RELU  = 0
) (
    input logic              clk,
    input logic              rst,
    linear2_neuron_mac_if.slave bus
);
    localparam int CW = $clog2(N + 1);
    localparam int RW = $clog2(N);
    localparam logic [CW-1:0] CNT_LAST   = CW'(N);
    localparam logic [CW-1:0] CNT_ROWMAX = CW'(N - 1);
    localparam logic [RW-1:0] ROW_LAST   = RW'(N - 1);
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << (DW - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

    state_t state, state_next;

    logic [CW-1:0]          cnt;
    logic signed [DW-1:0]   x_reg  [N];
    logic signed [DW-1:0]   w      [N];
    logic                   v1, v2;
    logic [RW-1:0]          r1, r2;
    logic signed [2*DW-1:0] prod   [N];
    logic signed [DW-1:0]   result [N];
    logic signed [DW-1:0]   res_next [N];
    logic signed [ACC_W-1:0] sum, shifted, relu_v;
    logic signed [DW-1:0]   sat;
    logic [N*DW-1:0]        y_pack;
    logic [N*DW-1:0]        y_reg;
    logic                   done_reg;
    logic                   mem_rd, busy;

    assign w[0] = bus.w0;
    assign w[1] = bus.w1;
    assign w[2] = bus.w2;
    assign w[3] = bus.w3;
    assign w[4] = bus.w4;
    assign w[5] = bus.w5;
    assign w[6] = bus.w6;
    assign w[7] = bus.w7;
    assign w[8] = bus.w8;
    assign w[9] = bus.w9;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (bus.start) state_next = READ;
            READ:    if (cnt == CNT_LAST) state_next = DRAIN;
            DRAIN:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        mem_rd = (state == READ);
        busy   = (state != IDLE);
    end

    assign bus.mem_rd = mem_rd;
    assign bus.busy   = busy;
    assign bus.done   = done_reg;
    assign bus.y_vec  = y_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            for (int unsigned k = 0; k < N; k++) x_reg[k] <= '0;
        end else if (state == IDLE && bus.start) begin
            cnt <= '0;
            for (int unsigned k = 0; k < N; k++) x_reg[k] <= bus.x_vec[k*DW +: DW];
        end else if (state == READ) begin
            cnt <= cnt + 1'b1;
        end
    end

    // The 11th rd strobe only rewinds the memory pointer, so it carries no row tag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1 <= 1'b0;
            r1 <= '0;
        end else begin
            v1 <= (state == READ) && (cnt <= CNT_ROWMAX);
            r1 <= cnt[RW-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v2 <= 1'b0;
            r2 <= '0;
            for (int unsigned k = 0; k < N; k++) prod[k] <= '0;
        end else begin
            v2 <= v1;
            r2 <= r1;
            if (v1) begin
                for (int unsigned k = 0; k < N; k++)
                    prod[k] <= (2*DW)'(w[k]) * (2*DW)'(x_reg[k]);
            end
        end
    end

    always_comb begin
        sum = '0;
        for (int unsigned k = 0; k < N; k++) sum = sum + ACC_W'(prod[k]);
        shifted = sum >>> FRAC;
        if (RELU != 0 && shifted[ACC_W-1]) relu_v = '0;
        else                               relu_v = shifted;
        if (relu_v > SAT_MAX)      sat = SAT_MAX[DW-1:0];
        else if (relu_v < SAT_MIN) sat = SAT_MIN[DW-1:0];
        else                       sat = relu_v[DW-1:0];
    end

    // The last row's result is merged before packing so y_vec updates atomically with done.
    always_comb begin
        for (int unsigned r = 0; r < N; r++) res_next[r] = result[r];
        if (v2) res_next[r2] = sat;
        y_pack = '0;
        for (int unsigned r = 0; r < N; r++) y_pack[r*DW +: DW] = res_next[r];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned r = 0; r < N; r++) result[r] <= '0;
            y_reg    <= '0;
            done_reg <= 1'b0;
        end else begin
            for (int unsigned r = 0; r < N; r++) result[r] <= res_next[r];
            done_reg <= v2 && (r2 == ROW_LAST);
            if (v2 && (r2 == ROW_LAST)) y_reg <= y_pack;
        end
    end
endmodule

// File: tb/tb_linear2_neuron_mac.sv
// Scoreboard bench for linear2_neuron_mac: RELU=0 and RELU=1 instances share one
// weight-memory model; expected results and cycle timing come from a dot-product model.
module tb_linear2_neuron_mac;
    localparam int DW = 10, N = 10, FRAC = 4, ACC_W = 24;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic            start;
    logic [N*DW-1:0] x_vec;
    logic signed [DW-1:0] wq [N];
    logic signed [DW-1:0] W  [N][N];
    logic            wr_en;
    int              ptr;
    int              cyc;

    linear2_neuron_mac_if #(.DW(DW), .N(N)) bus0 ();
    linear2_neuron_mac_if #(.DW(DW), .N(N)) bus1 ();

    linear2_neuron_mac #(.DW(DW), .N(N), .FRAC(FRAC), .ACC_W(ACC_W), .RELU(0)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0));
    linear2_neuron_mac #(.DW(DW), .N(N), .FRAC(FRAC), .ACC_W(ACC_W), .RELU(1)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1));

    assign bus0.start = start;  assign bus1.start = start;
    assign bus0.x_vec = x_vec;  assign bus1.x_vec = x_vec;
    assign bus0.w0 = wq[0];     assign bus1.w0 = wq[0];
    assign bus0.w1 = wq[1];     assign bus1.w1 = wq[1];
    assign bus0.w2 = wq[2];     assign bus1.w2 = wq[2];
    assign bus0.w3 = wq[3];     assign bus1.w3 = wq[3];
    assign bus0.w4 = wq[4];     assign bus1.w4 = wq[4];
    assign bus0.w5 = wq[5];     assign bus1.w5 = wq[5];
    assign bus0.w6 = wq[6];     assign bus1.w6 = wq[6];
    assign bus0.w7 = wq[7];     assign bus1.w7 = wq[7];
    assign bus0.w8 = wq[8];     assign bus1.w8 = wq[8];
    assign bus0.w9 = wq[9];     assign bus1.w9 = wq[9];

    always @(posedge clk) cyc <= cyc + 1;

    // Weight memory: a write phase rewinds the pointer; rd edges fetch rows, then wrap.
    always @(posedge clk) begin
        if (wr_en) ptr <= 0;
        else if (bus0.mem_rd) begin
            if (ptr < N) begin
                for (int k = 0; k < N; k++) wq[k] <= W[ptr][k];
                ptr <= ptr + 1;
            end else ptr <= 0;
        end
    end

    typedef struct {
        logic [N*DW-1:0] y0;
        logic [N*DW-1:0] y1;
        int              acc;
    } exp_t;
    exp_t q[$];

    int n_pass = 0, n_tot = 0;
    logic [N*DW-1:0] last_y0 = '0, last_y1 = '0;
    int idle_at = 0, last_acc = 0;

    task automatic chkv(input string name, input logic [N*DW-1:0] got, input logic [N*DW-1:0] exp);
        n_tot++;
        if (got === exp) n_pass++;
        else $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, got, exp);
    endtask

    task automatic chk1(input string name, input logic got, input logic exp);
        n_tot++;
        if (got === exp) n_pass++;
        else $display("FAIL %s at cycle %0d: got %b expected %b", name, cyc, got, exp);
    endtask

    function automatic logic [N*DW-1:0] model(input logic [N*DW-1:0] xv, input bit relu);
        logic [N*DW-1:0] y;
        logic signed [DW-1:0] xk;
        int s;
        y = '0;
        for (int r = 0; r < N; r++) begin
            s = 0;
            for (int k = 0; k < N; k++) begin
                xk = xv[k*DW +: DW];
                s += int'(W[r][k]) * int'(xk);
            end
            s = s >>> FRAC;
            if (relu && s < 0) s = 0;
            if (s > 511)  s = 511;
            if (s < -512) s = -512;
            y[r*DW +: DW] = DW'(s);
        end
        return y;
    endfunction

    function automatic logic [N*DW-1:0] x_fill(input int base, input int step);
        logic [N*DW-1:0] xv;
        for (int k = 0; k < N; k++) xv[k*DW +: DW] = DW'(base + step * k);
        return xv;
    endfunction

    function automatic logic [N*DW-1:0] x_rand();
        logic [N*DW-1:0] xv;
        for (int k = 0; k < N; k++) xv[k*DW +: DW] = DW'($urandom);
        return xv;
    endfunction

    // Timing expectations relative to the accepting edge A:
    // mem_rd for A..A+10, busy for A..A+11, done and new y_vec at A+12.
    always @(negedge clk) begin : monitor
        bit ed, eb, er;
        if (!rst) begin
            ed = q.size() > 0 && cyc == q[0].acc + 12;
            eb = q.size() > 0 && cyc <  q[0].acc + 12;
            er = q.size() > 0 && cyc <= q[0].acc + 10;
            chk1("done0", bus0.done, ed);
            chk1("done1", bus1.done, ed);
            chk1("busy", bus0.busy, eb);
            chk1("mem_rd", bus0.mem_rd, er);
            if (ed) begin
                chkv("y_relu0", bus0.y_vec, q[0].y0);
                chkv("y_relu1", bus1.y_vec, q[0].y1);
                chk1("ptr_zero", ptr == 0, 1'b1);
                last_y0 = q[0].y0;
                last_y1 = q[0].y1;
                void'(q.pop_front());
            end else begin
                chkv("y_hold0", bus0.y_vec, last_y0);
                chkv("y_hold1", bus1.y_vec, last_y1);
            end
        end
    end

    task automatic goto_neg(input int c);
        @(negedge clk);
        while (cyc < c) @(negedge clk);
    endtask

    // Called at a negedge; the start is sampled at the next rising edge.
    task automatic pulse(input logic [N*DW-1:0] xv);
        bit acc;
        exp_t e;
        acc = (cyc >= idle_at);
        start = 1'b1;
        x_vec = xv;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (acc) begin
            e.y0 = model(xv, 1'b0);
            e.y1 = model(xv, 1'b1);
            e.acc = cyc;
            q.push_back(e);
            last_acc = cyc;
            idle_at = cyc + 12;
        end
        x_vec = x_rand();
    endtask

    task automatic run(input logic [N*DW-1:0] xv, input int gap);
        goto_neg(idle_at + gap);
        pulse(xv);
    endtask

    task automatic set_w(input int mode);
        for (int r = 0; r < N; r++)
            for (int k = 0; k < N; k++)
                case (mode)
                    0:       W[r][k] = (r == k) ? DW'(16) : '0;
                    1:       W[r][k] = DW'(511);
                    2:       W[r][k] = DW'(16);
                    3:       W[r][k] = DW'($urandom);
                    default: W[r][k] = DW'(int'($urandom_range(0, 63)) - 32);
                endcase
    endtask

    task automatic load_w(input int mode);
        goto_neg(idle_at);
        set_w(mode);
        wr_en = 1'b1;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        wr_en = 1'b0;
        x_vec = '0;
        repeat (2) @(posedge clk);
        #1;
        chk1("rst_done", bus0.done, 1'b0);
        chk1("rst_busy", bus0.busy, 1'b0);
        chk1("rst_mem_rd", bus0.mem_rd, 1'b0);
        chkv("rst_y", bus0.y_vec, '0);
        rst = 1'b0;

        // identity, then a start in the done cycle with new activations
        load_w(0);
        run(x_fill(-5, 1), 0);
        goto_neg(last_acc + 12);
        pulse(x_fill(4, -1));

        // saturation both ways
        load_w(1);
        run(x_fill(511, 0), 0);
        run(x_fill(-512, 0), 1);

        // starts while busy are ignored
        load_w(0);
        run(x_rand(), 0);
        goto_neg(last_acc + 2);
        pulse(x_rand());
        goto_neg(last_acc + 6);
        pulse(x_rand());

        // async reset mid-run, then reload and rerun identity
        run(x_rand(), 2);
        goto_neg(last_acc + 4);
        @(posedge clk);
        #3;
        rst = 1'b1;
        q.delete();
        last_y0 = '0;
        last_y1 = '0;
        #1;
        chk1("rst_mid_mem_rd", bus0.mem_rd, 1'b0);
        chk1("rst_mid_busy", bus0.busy, 1'b0);
        chk1("rst_mid_done", bus0.done, 1'b0);
        chkv("rst_mid_y", bus0.y_vec, '0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        idle_at = cyc;
        load_w(0);
        run(x_fill(-5, 1), 0);

        // ReLU clamp versus signed pass-through
        load_w(2);
        run(x_fill(-1, 0), 0);

        for (int i = 0; i < 30; i++) begin
            if (i % 5 == 0) load_w((i % 10 == 0) ? 3 : 4);
            run(x_rand(), int'($urandom_range(0, 2)));
        end

        goto_neg(idle_at + 3);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
